fetch_ctrl: RTL and testbench

Instruction-fetch controller that sequences the word-addressed instruction ROM of the MIPS core. Owns the fetch PC, presents byte addresses to the ROM, captures returned words with their PC into a small prefetch buffer, and hands them to decode over a valid/ready handshake. It sits between the branch/jump redirect logic and the decoder, and absorbs decode stalls without losing or duplicating instructions.

---
 rtl/fetch_pkg.sv | 27 ++
 rtl/fetch_buf.sv | 61 ++++++
 rtl/fetch_ctrl.sv | 111 +++++++++++
 tb/tb_fetch_ctrl.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch types and defaults; in_bounds() is the ROM window test used when
// FETCH_BOUNDS_EN is defined.
package fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_3000;
  localparam int unsigned IM_WORDS_DEFAULT  = 1024;
  localparam int unsigned BUF_DEPTH_DEFAULT = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } fetch_entry_t;

  // 33-bit compare so a window ending at 2^32 does not wrap to zero
  function automatic logic in_bounds(input logic [31:0] pc,
                                     input logic [31:0] base,
                                     input int unsigned words);
    logic [32:0] lo;
    logic [32:0] hi;
    logic [32:0] a;
    lo = {1'b0, base};
    hi = lo + ({1'b0, 32'(words)} << 2);
    a  = {1'b0, pc};
    return (a >= lo) && (a < hi);
  endfunction

endpackage

// File: rtl/fetch_buf.sv
// Circular prefetch FIFO of {pc, word} entries; head visible in the cycle after the push.
// Push is dropped when full unless a pop frees a slot in the same cycle; flush empties it.
module fetch_buf
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  fetch_entry_t  push_entry,
  input  logic          pop,
  input  logic          flush,
  output logic [CW-1:0] count,
  output logic          head_valid,
  output fetch_entry_t  head_entry
);

  localparam int unsigned PW = $clog2(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop && (cnt != '0);
  assign do_push = push && ((cnt != CW'(DEPTH)) || do_pop);

  // DEPTH is a power of two, so the pointers wrap on their own
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  assign count      = cnt;
  assign head_valid = (cnt != '0);
  assign head_entry = mem[rd_ptr];

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch PC owner: one ROM word per cycle into fetch_buf, redirect flushes and retargets.
// Optional FETCH_BOUNDS_EN adds a sticky out-of-window fault; decode stalls via ins_ready.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int unsigned IM_WORDS  = IM_WORDS_DEFAULT,
  parameter int unsigned BUF_DEPTH = BUF_DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        ins_valid,
  input  logic        ins_ready,
  output logic [31:0] ins_word,
  output logic [31:0] ins_pc,
  output logic        fetch_fault
);

  localparam int unsigned CW = $clog2(BUF_DEPTH + 1);

  if (BUF_DEPTH < 2 || (BUF_DEPTH & (BUF_DEPTH - 1)) != 0 || IM_WORDS == 0) begin : g_bad_cfg
    $error("fetch_ctrl: BUF_DEPTH must be a power of two >= 2 and IM_WORDS nonzero");
  end

  logic [31:0]  fpc;
  logic [31:0]  fpc_nxt;
  logic [31:0]  target;
  logic [CW-1:0] buf_count;
  logic         pop;
  logic         fetch_try;
  logic         push;
  logic         fault;
  fetch_entry_t push_entry;
  fetch_entry_t head_entry;
  logic         unused_lsbs;

  assign target      = {redirect_pc[31:2], 2'b00};
  assign unused_lsbs = ^redirect_pc[1:0];

  assign pop       = ins_valid & ins_ready;
  assign fetch_try = !redirect_valid && !halt && !fault &&
                     ((buf_count < CW'(BUF_DEPTH)) || pop);

`ifdef FETCH_BOUNDS_EN
  logic fpc_ok;
  assign fpc_ok = in_bounds(fpc, RESET_PC, IM_WORDS);
  assign push   = fetch_try && fpc_ok;

  // Only an in-window redirect target releases the fault; fpc stays frozen meanwhile
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fault <= 1'b0;
    end else if (redirect_valid) begin
      if (in_bounds(target, RESET_PC, IM_WORDS)) begin
        fault <= 1'b0;
      end
    end else if (fetch_try && !fpc_ok) begin
      fault <= 1'b1;
    end
  end
`else
  assign push  = fetch_try;
  assign fault = 1'b0;
`endif

  assign fetch_fault = fault;

  always_comb begin
    fpc_nxt = fpc;
    if (redirect_valid) begin
      fpc_nxt = target;
    end else if (push) begin
      fpc_nxt = fpc + 32'd4;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fpc <= RESET_PC;
    end else begin
      fpc <= fpc_nxt;
    end
  end

  assign imem_addr       = fpc;
  assign push_entry.pc   = fpc;
  assign push_entry.word = imem_rdata;

  fetch_buf #(
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (redirect_valid),
    .count      (buf_count),
    .head_valid (ins_valid),
    .head_entry (head_entry)
  );

  assign ins_pc   = head_entry.pc;
  assign ins_word = head_entry.word;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed scenarios for fetch_ctrl; expected {pc, word} pairs are queued by the
// stimulus and matched by a monitor on every decode handshake.
module tb_fetch_ctrl;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        ins_valid;
  logic        ins_ready;
  logic [31:0] ins_word;
  logic [31:0] ins_pc;
  logic        fetch_fault;

  logic [31:0]  im [1024];
  fetch_entry_t exp_q [$];
  fetch_entry_t mon_e;
  int           n_tests = 0;
  int           n_fail  = 0;

  always #5 clk = ~clk;

  assign imem_rdata = im[imem_addr[11:2]];

  fetch_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .ins_valid      (ins_valid),
    .ins_ready      (ins_ready),
    .ins_word       (ins_word),
    .ins_pc         (ins_pc),
    .fetch_fault    (fetch_fault)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, req);
    end
  endtask

  task automatic expect_ins(input logic [31:0] pc, input logic [31:0] word);
    fetch_entry_t e;
    e.pc   = pc;
    e.word = word;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Handshake sampled mid-cycle; it completes at the following rising edge
  always @(negedge clk) begin
    if (reset === 1'b1 && ins_valid === 1'b1 && ins_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_ins: got pc=%h word=%h, want no instruction", ins_pc, ins_word);
      end else begin
        mon_e = exp_q.pop_front();
        check("ins_pc", ins_pc, mon_e.pc);
        check("ins_word", ins_word, mon_e.word);
      end
    end
  end

  task automatic finish_scn();
    ins_ready      = 1'b0;
    halt           = 1'b0;
    redirect_valid = 1'b0;
    reset          = 1'b0;
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    step();
  endtask

  // Entered with reset held low
  task automatic scn_first();
    check("rst_ins_valid", 32'(ins_valid), 32'd0);
    check("rst_ins_pc", ins_pc, 32'd0);
    check("rst_ins_word", ins_word, 32'd0);
    check("rst_imem_addr", imem_addr, 32'h0000_3000);
    check("rst_fetch_fault", 32'(fetch_fault), 32'd0);
    ins_ready = 1'b1;
    expect_ins(32'h3000, 32'h3C01_0001);
    expect_ins(32'h3004, 32'h3421_0002);
    expect_ins(32'h3008, 32'h0001_1020);
    reset = 1'b1;
    step();
    check("first_valid", 32'(ins_valid), 32'd1);
    step();
    check("stream_valid_1", 32'(ins_valid), 32'd1);
    step();
    check("stream_valid_2", 32'(ins_valid), 32'd1);
    step();
    finish_scn();
  endtask

  task automatic scn_backpressure();
    ins_ready = 1'b0;
    reset     = 1'b1;
    repeat (5) step();
    check("bp_imem_addr", imem_addr, 32'h3008);
    check("bp_valid", 32'(ins_valid), 32'd1);
    check("bp_head_pc", ins_pc, 32'h3000);
    expect_ins(32'h3000, 32'h3C01_0001);
    expect_ins(32'h3004, 32'h3421_0002);
    expect_ins(32'h3008, 32'h0001_1020);
    ins_ready = 1'b1;
    step();
    check("bp_drain_valid_1", 32'(ins_valid), 32'd1);
    step();
    check("bp_drain_valid_2", 32'(ins_valid), 32'd1);
    step();
    finish_scn();
  endtask

  task automatic scn_redirect();
    ins_ready = 1'b0;
    reset     = 1'b1;
    repeat (3) step();
    check("rd_full_valid", 32'(ins_valid), 32'd1);
    expect_ins(32'h3000, 32'h3C01_0001);
    ins_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_3043;
    step();
    redirect_valid = 1'b0;
    check("rd_flush_valid", 32'(ins_valid), 32'd0);
    check("rd_imem_addr", imem_addr, 32'h3040);
    expect_ins(32'h3040, 32'h2400_0010);
    expect_ins(32'h3044, 32'h2400_0011);
    step();
    check("rd_target_valid", 32'(ins_valid), 32'd1);
    step();
    step();
    finish_scn();
  endtask

  task automatic scn_halt();
    ins_ready = 1'b0;
    reset     = 1'b1;
    repeat (3) step();
    expect_ins(32'h3000, 32'h3C01_0001);
    expect_ins(32'h3004, 32'h3421_0002);
    halt      = 1'b1;
    ins_ready = 1'b1;
    step();
    step();
    check("halt_drained_valid", 32'(ins_valid), 32'd0);
    check("halt_imem_addr", imem_addr, 32'h3008);
    step();
    check("halt_frozen_addr", imem_addr, 32'h3008);
    check("halt_idle_valid", 32'(ins_valid), 32'd0);
    halt = 1'b0;
    expect_ins(32'h3008, 32'h0001_1020);
    expect_ins(32'h300C, 32'h2400_0003);
    step();
    check("halt_resume_valid", 32'(ins_valid), 32'd1);
    step();
    step();
    finish_scn();
  endtask

  task automatic scn_bounds();
    ins_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_4000;
    reset          = 1'b1;
    step();
    redirect_valid = 1'b0;
    check("bnd_redir_valid", 32'(ins_valid), 32'd0);
    check("bnd_imem_addr", imem_addr, 32'h4000);
`ifdef FETCH_BOUNDS_EN
    step();
    check("bnd_fault_set", 32'(fetch_fault), 32'd1);
    check("bnd_no_push", 32'(ins_valid), 32'd0);
    step();
    check("bnd_fault_sticky", 32'(fetch_fault), 32'd1);
    check("bnd_still_empty", 32'(ins_valid), 32'd0);
    check("bnd_addr_held", imem_addr, 32'h4000);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_3000;
    step();
    redirect_valid = 1'b0;
    check("bnd_fault_clear", 32'(fetch_fault), 32'd0);
    expect_ins(32'h3000, 32'h3C01_0001);
    expect_ins(32'h3004, 32'h3421_0002);
    step();
    check("bnd_resume_valid", 32'(ins_valid), 32'd1);
    step();
    step();
`else
    expect_ins(32'h4000, 32'h3C01_0001);
    expect_ins(32'h4004, 32'h3421_0002);
    step();
    check("alias_valid", 32'(ins_valid), 32'd1);
    check("alias_no_fault", 32'(fetch_fault), 32'd0);
    step();
    step();
`endif
    finish_scn();
  endtask

`ifndef FETCH_BOUNDS_EN
  task automatic scn_wrap();
    ins_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    reset          = 1'b1;
    step();
    redirect_valid = 1'b0;
    check("wrap_addr_top", imem_addr, 32'hFFFF_FFFC);
    expect_ins(32'hFFFF_FFFC, 32'h2400_03FF);
    expect_ins(32'h0000_0000, 32'h3C01_0001);
    step();
    check("wrap_addr_zero", imem_addr, 32'h0000_0000);
    step();
    step();
    finish_scn();
  endtask
`endif

  task automatic scn_reset_mid();
    ins_ready = 1'b0;
    reset     = 1'b1;
    repeat (3) step();
    check("mid_full_valid", 32'(ins_valid), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_valid", 32'(ins_valid), 32'd0);
    check("mid_rst_addr", imem_addr, 32'h0000_3000);
    check("mid_rst_pc", ins_pc, 32'd0);
    check("mid_rst_word", ins_word, 32'd0);
    scn_first();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want run completion");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 1024; i++) begin
      im[i] = 32'h2400_0000 | 32'(i);
    end
    im[0] = 32'h3C01_0001;
    im[1] = 32'h3421_0002;
    im[2] = 32'h0001_1020;

    reset          = 1'b0;
    ins_ready      = 1'b0;
    halt           = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    step();
    step();

    scn_first();
    scn_backpressure();
    scn_redirect();
    scn_halt();
    scn_bounds();
`ifndef FETCH_BOUNDS_EN
    scn_wrap();
`endif
    scn_reset_mid();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
